// File: rtl/imem_arbiter.sv
// ============================================================================
// imem_arbiter
// Shares one combinational instruction-memory read port between two
// valid/ready requesters using round-robin grant and registered responses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp0_err,
  input  logic          rsp0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic          rsp1_err,
  input  logic          rsp1_ready,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          prio;
  logic          owner;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          gnt0, gnt1;
  logic          rsp_hs;

  // A lone requester wins outright; contention is resolved by prio.
  assign gnt0 = req0_valid & (~req1_valid | ~prio);
  assign gnt1 = req1_valid & (~req0_valid |  prio);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_hs     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 || gnt1) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid =  owner;
        rsp_hs     = owner ? rsp1_ready : rsp0_ready;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Non-owner response channel reads zero; the owner sees the held word.
  assign rsp0_data = rsp0_valid ? data_q : '0;
  assign rsp0_err  = rsp0_valid & err_q;
  assign rsp1_data = rsp1_valid ? data_q : '0;
  assign rsp1_err  = rsp1_valid & err_q;
  assign mem_addr  = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      prio   <= 1'b0;
      owner  <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (gnt0 || gnt1)) begin
        addr_q <= gnt1 ? req1_addr : req0_addr;
        owner  <= gnt1;
        prio   <= ~gnt1;
        err_q  <= gnt1 ? (req1_addr[1:0] != 2'b00) : (req0_addr[1:0] != 2'b00);
      end
      if (state == ISSUE) data_q <= err_q ? '0 : mem_rd;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ============================================================================
// tb_imem_arbiter
// Directed scoreboard bench for imem_arbiter. Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_imem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic          rsp0_err, rsp1_err;
  logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd;

  always #5 clk = ~clk;

  imem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
    .mem_addr(mem_addr), .mem_rd(mem_rd)
  );

  // Instruction memory contents; unmapped addresses return a marker word.
  always_comb begin
    case (mem_addr)
      8'h00:   mem_rd = 32'h00100193;
      8'h04:   mem_rd = 32'h0FF00083;
      8'h08:   mem_rd = 32'h0030F133;
      default: mem_rd = 32'hDEADBEEF;
    endcase
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 64'(rsp0_valid), 64'd0);
        else chk("rsp0_payload", 64'({rsp0_err, rsp0_data}), 64'(q0.pop_front()));
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 64'(rsp1_valid), 64'd0);
        else chk("rsp1_payload", 64'({rsp1_err, rsp1_data}), 64'(q1.pop_front()));
      end
      if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 64'd1, 64'd0);
    end
  end

  task automatic wait_grant(input int port, output int ok, output int waited);
    ok = 0;
    waited = 0;
    while (waited < 20) begin
      @(negedge clk);
      if (port == 0 ? req0_ready : req1_ready) begin
        ok = 1;
        break;
      end
      waited++;
    end
    chk($sformatf("grant%0d_seen", port), 64'(ok), 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction with latency checks; rsp ready is held high.
  task automatic single(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    int ok, waited;
    if (port == 0) begin req0_valid = 1'b1; req0_addr = a; end
    else           begin req1_valid = 1'b1; req1_addr = a; end
    wait_grant(port, ok, waited);
    chk("accept_latency", 64'(waited), 64'd0);
    chk("other_ready_low", 64'(port == 0 ? req1_ready : req0_ready), 64'd0);
    if (ok == 1) begin
      if (port == 0) q0.push_back({e, d});
      else           q1.push_back({e, d});
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("issue_rsp_low", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    chk("issue_mem_addr", 64'(mem_addr), 64'(a));
    @(negedge clk);
    chk("resp_valid", 64'(port == 0 ? rsp0_valid : rsp1_valid), 64'd1);
    chk("other_quiet", 64'(port == 0 ? {rsp1_valid, rsp1_err, rsp1_data} : {rsp0_valid, rsp0_err, rsp0_data}), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ok, waited, last;
    int exp_port[4] = '{0, 1, 0, 1};

    // Reset values
    #2;
    chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    chk("rst_rsp", 64'({rsp0_valid, rsp0_err, rsp0_data, rsp1_valid, rsp1_err}), 64'd0);
    chk("rst_rsp1_data", 64'(rsp1_data), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 64'd0);
    end
    @(posedge clk);
    #1;

    // Port 0 alone, then a misaligned port 0 request
    single(0, 8'h08, 32'h0030F133, 1'b0);
    wait_drain();
    single(0, 8'h0A, 32'h00000000, 1'b1);
    wait_drain();

    // Both requesting continuously: strict alternation from prio 0
    pulse_reset();
    req0_valid = 1'b1; req0_addr = 8'h00;
    req1_valid = 1'b1; req1_addr = 8'h04;
    last = 0;
    for (int g = 0; g < 4; g++) begin
      ok = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin ok = 1; break; end
      end
      chk("alt_grant_seen", 64'(ok), 64'd1);
      chk("alt_grant_port", 64'(req1_ready), 64'(exp_port[g]));
      chk("alt_one_ready", 64'(req0_ready & req1_ready), 64'd0);
      if (g > 0) chk("alt_gap", 64'(cyc - last), 64'd3);
      last = cyc;
      if (exp_port[g] == 0) q0.push_back({1'b0, 32'h00100193});
      else                  q1.push_back({1'b0, 32'h0FF00083});
      @(posedge clk);
      if (g == 3) begin
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    wait_drain();

    // Backpressure on port 1 while port 0 waits
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_addr = 8'h04;
    wait_grant(1, ok, waited);
    if (ok == 1) q1.push_back({1'b0, 32'h0FF00083});
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp1_valid), 64'd1);
      chk("bp_data", 64'({rsp1_err, rsp1_data}), 64'({1'b0, 32'h0FF00083}));
      chk("bp_req0_ready", 64'(req0_ready), 64'd0);
      chk("bp_mem_addr", 64'(mem_addr), 64'h04);
    end
    @(posedge clk);
    #1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_port0_next", 64'(req0_ready), 64'd1);
    if (req0_ready) q0.push_back({1'b0, 32'h00100193});
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_drain();

    // Reset during ISSUE
    req0_valid = 1'b1; req0_addr = 8'h08;
    wait_grant(0, ok, waited);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_issue_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    chk("rst_issue_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_issue_quiet", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_addr = 8'h00;
    req1_valid = 1'b1; req1_addr = 8'h04;
    @(negedge clk);
    chk("rst_issue_prio", 64'({req0_ready, req1_ready}), 64'b10);
    if (req0_ready) q0.push_back({1'b0, 32'h00100193});
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();

    // Reset during RESP with the response held back
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'h08;
    wait_grant(0, ok, waited);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_resp_pre", 64'(rsp0_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_resp_drop", 64'({rsp0_valid, rsp0_err, rsp0_data}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_resp_quiet", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_addr = 8'h00;
    req1_valid = 1'b1; req1_addr = 8'h04;
    @(negedge clk);
    chk("rst_resp_prio", 64'({req0_ready, req1_ready}), 64'b10);
    if (req0_ready) q0.push_back({1'b0, 32'h00100193});
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter sharing the single combinational instruction-memory read port (8-bit byte address, 32-bit word) between the CPU fetch path (port 0) and the debug/trace reader (port 1). It accepts valid/ready requests, grants one at a time with round-robin priority, drives the memory address, registers the returned word and holds it on the winner's response channel until that requester consumes it. Misaligned addresses are flagged rather than issued.

## Interface
- AW, 8: memory byte-address width
- DW, 32: memory word width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 request valid
- req0_addr  in  AW  port 0 byte address
- req0_ready  out  1  port 0 request accepted this cycle when high together with req0_valid
- rsp0_valid  out  1  port 0 response valid
- rsp0_data  out  DW  port 0 response word
- rsp0_err  out  1  port 0 misaligned-address flag, qualified by rsp0_valid
- rsp0_ready  in  1  port 0 consumes response
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_err, rsp1_ready: same as port 0, for port 1
- mem_addr  out  AW  address to the instruction memory
- mem_rd  in  DW  combinational read data from the instruction memory

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: grant computed combinationally from req*_valid and the priority pointer `prio` (0 = port 0 preferred). Only one of req0_ready/req1_ready is high; it is high only in IDLE and only for the granted port with valid asserted. No requests -> both ready low, stay in IDLE.
- On acceptance: latch address into `addr_q`, winner into `owner`; set `prio` to the non-winning port; `err_q` = (addr[1:0] != 0). Go to ISSUE.
- ISSUE: mem_addr = addr_q. At the clock edge capture `data_q` = err_q ? 0 : mem_rd. Go to RESP.
- RESP: rsp{owner}_valid = 1, data = data_q, err = err_q; the other port's rsp_valid = 0. On rsp{owner}_ready, return to IDLE. Data and err are stable while valid is high and ready is low.
- Response data of the non-owner port reads 0.
- mem_addr outside ISSUE holds addr_q (no glitching to requester addresses).
- Single requester: always granted regardless of `prio`.
- Both requesting: `prio` port wins; strict alternation while both keep requesting.
- Requester dropping valid while not granted is legal; no state retained for it.
- Reset mid-transaction (any state): immediately IDLE, response discarded, no response later issued.

## Timing
- Reset values: req*_ready 0 (IDLE with no valid), rsp*_valid 0, rsp*_data 0, rsp*_err 0, mem_addr 0, prio 0, addr_q 0, data_q 0.
- Accept at edge N (IDLE, valid&ready) -> ISSUE during cycle N+1 -> rsp_valid high from cycle N+2.
- With rsp_ready held high: response handshakes in cycle N+2, IDLE in N+3; next acceptance no earlier than N+3. Throughput one transaction per 3 cycles.
- rsp_ready has no combinational path to req*_ready; req*_ready depends only on state, prio and req*_valid.
- mem_rd sampled only at the end of ISSUE; memory combinational delay must fit one cycle from addr_q.

## Test plan
- Reset: rst_n low -> all outputs 0; release with no requests -> ready/valid stay 0 for 10 cycles.
- Port 0 alone, req0_addr=0x08, memory returns 0x0030F133 -> req0_ready at accept cycle, rsp0_valid two cycles later with rsp0_data=0x0030F133, rsp0_err=0, port 1 outputs quiet.
- Both ports valid continuously, addrs 0x00/0x04, rsp ready tied high -> grants port0, port1, port0, port1; data 0x00100193 to port 0, 0x0FF00083 to port 1; one grant per 3 cycles.
- Backpressure: port 1 wins, rsp1_ready low for 5 cycles -> rsp1_valid/data stable, req0_ready stays low, mem_addr unchanged; release -> port 0 granted next IDLE cycle.
- Misaligned: req0_addr=0x0A -> rsp0_err=1, rsp0_data=0, latency unchanged.
- Reset asserted during ISSUE and during RESP -> rsp valid drops asynchronously, no response after release, prio back to 0.
